mem_mfc_responder: RTL and testbench
====================================

Name: mem_mfc_responder

Overview:
Memory-side responder for the CPU controller's read/write/MFC handshake. It latches the address (from MAR) and write data (from MDR) on a request, inserts a configurable number of wait states, and performs the access on an internal word-addressed RAM. It then raises mfc and holds it until the controller drops read/write (4-phase handshake). It sits between the controller/MAR/MDR and the data bus, and replaces the hand-driven MFC stimulus used in benches today.

Parameters:
ADDR_WIDTH, 8, RAM depth is 2**ADDR_WIDTH words; only addr[ADDR_WIDTH-1:0] is used.
DATA_WIDTH, 16, word width.
WAIT_STATES, 2, extra cycles between request acceptance and the access (0..15).

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
read  input  1  read request from controller, level.
write  input  1  write request from controller, level.
addr  input  16  word address (MAR output).
wdata  input  DATA_WIDTH  write data (MDR output).
rdata  output  DATA_WIDTH  read data, registered.
rdata_oe  output  1  high while rdata is valid and driven toward MDR/DBUS.
mfc  output  1  memory function complete.
busy  output  1  high in ACCESS or DONE.
protocol_err  output  1  sticky; set when read and write are both high on an edge.
rd_count  output  16  completed reads, wraps at 16'hFFFF->0.
wr_count  output  16  completed writes, wraps.

Behaviour:
- Reset: synchronous, takes priority over all other logic. It sets state=IDLE, rdata=0, rdata_oe=0, mfc=0, busy=0, protocol_err=0, rd_count=0, wr_count=0, and clears the wait counter. RAM contents are NOT cleared. Reset mid-access aborts the access: no RAM write, no count increment.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - read XOR write at an edge: latch op, addr[ADDR_WIDTH-1:0], and wdata; load cnt=WAIT_STATES; go to ACCESS; busy=1.
  - read AND write: no access, stay in IDLE, set protocol_err.
- ACCESS, at each edge:
  - If the latched op's request line is low, or both lines are high: abort. Go to IDLE, busy=0, no RAM write, no count change. Set protocol_err if both lines are high.
  - Else if cnt!=0: decrement cnt.
  - Else (cnt==0): perform the access, set mfc=1, go to DONE.
    - Write: mem[addr_l]<=wdata_l; wr_count+1.
    - Read: rdata<=mem[addr_l]; rdata_oe=1; rd_count+1.
- Latency: the request is sampled at edge E0. mfc is high after edge E0+1+WAIT_STATES. With defaults, mfc rises 3 edges after acceptance.
- DONE:
  - mfc holds 1 while read or write is high. A new or opposite request does not start until both lines are low.
  - read=0 and write=0 at an edge: mfc=0, rdata_oe=0, busy=0, go to IDLE.
  - rdata keeps its last value after leaving DONE.
  - The earliest next acceptance is the edge after returning to IDLE.
- Addresses: addr bits above ADDR_WIDTH-1 are ignored, so addresses alias modulo 2**ADDR_WIDTH. Inputs changing after acceptance do not affect the in-flight access.
- Read-after-write to the same address returns the new data.
- protocol_err clears only on reset.

Test Plan:
1. Write then read: write=1, addr=16'h0010, wdata=16'hBEEF until mfc; drop write; then read=1, addr=16'h0010 until mfc. Required: mfc rises 3 edges after each acceptance. After the read, rdata=16'hBEEF and rdata_oe=1 until read drops. wr_count=1, rd_count=1.
2. Handshake hold: hold read=1 for 10 cycles after mfc rises. Required: mfc stays 1 and no second access occurs (rd_count unchanged). mfc=0 and rdata_oe=0 one edge after read drops.
3. WAIT_STATES=0: write 16'h1234 to addr 5, then read addr 5. Required: mfc after edge E0+1 for both accesses; rdata=16'h1234.
4. Abort and alias: write 16'hAAAA to addr 3 and complete it. Then start write 16'h5555 to addr 16'h0103 and drop write after 1 cycle (before mfc). Required: mfc never rises and wr_count is unchanged. A following read of 16'h0003 returns 16'hAAAA. A write to 16'h0103 that does complete is readable at addr 3 (aliasing).
5. Protocol error: assert read=1 and write=1 together in IDLE. Required: protocol_err=1, busy stays 0, no RAM change. protocol_err remains 1 after both lines drop and clears only on reset.
6. Reset mid-access: start a write of 16'hFFFF to addr 7 (previously 16'h0042) and pulse reset during ACCESS. Required: all outputs return to their reset values. A later read of addr 7 returns 16'h0042, and wr_count=0 after reset.

Source files
------------

// File: rtl/mem_mfc_responder.sv
// mem_mfc_responder: memory-side responder for the controller read/write/MFC 4-phase handshake.
// Latency: request sampled at edge E0, mfc high after edge E0+1+WAIT_STATES; held until read/write both drop.
// Backpressure: a new request is not accepted until both request lines are low and the FSM is back in IDLE.
//
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   read, write         - level requests from the controller
//   addr, wdata         - word address (MAR) and write data (MDR), latched on acceptance
//   rdata, rdata_oe     - registered read data and its drive enable toward MDR/DBUS
//   mfc, busy           - memory function complete; high while in ACCESS or DONE
//   protocol_err        - sticky flag, set whenever read and write are both high on an edge
//   rd_count, wr_count  - completed read/write counters, wrap at 16 bits
module mem_mfc_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [15:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_oe,
    output logic                  mfc,
    output logic                  busy,
    output logic                  protocol_err,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_op_wr;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [3:0]              r_cnt;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_rdata_oe;
    logic                    r_mfc;
    logic                    r_busy;
    logic                    r_protocol_err;
    logic [15:0]             r_rd_count;
    logic [15:0]             r_wr_count;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    // Upper address bits are dropped here, which makes addresses alias modulo DEPTH.
    logic [ADDR_WIDTH-1:0]   w_addr_idx;
    logic                    w_both;
    logic                    w_req_live;
    logic                    w_do_access;
    logic                    w_mem_we;

    assign w_addr_idx  = ADDR_WIDTH'(addr);
    assign w_both      = read & write;
    // The in-flight access stays alive only while its own request line is held.
    assign w_req_live  = r_op_wr ? write : read;
    assign w_do_access = (r_state == S_ACCESS) && w_req_live && !w_both && (r_cnt == 4'd0);
    // Reset aborts the access in the same cycle, so it also gates the RAM write.
    assign w_mem_we    = !reset && w_do_access && r_op_wr;

    // RAM is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_op_wr        <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_cnt          <= 4'd0;
            r_rdata        <= '0;
            r_rdata_oe     <= 1'b0;
            r_mfc          <= 1'b0;
            r_busy         <= 1'b0;
            r_protocol_err <= 1'b0;
            r_rd_count     <= 16'd0;
            r_wr_count     <= 16'd0;
        end else begin
            if (w_both) begin
                r_protocol_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (read ^ write) begin
                        r_op_wr <= write;
                        r_addr  <= w_addr_idx;
                        r_wdata <= wdata;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_busy  <= 1'b1;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!w_req_live || w_both) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (r_op_wr) begin
                            r_wr_count <= r_wr_count + 16'd1;
                        end else begin
                            r_rdata    <= r_mem[r_addr];
                            r_rdata_oe <= 1'b1;
                            r_rd_count <= r_rd_count + 16'd1;
                        end
                        r_mfc   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Completion of the 4-phase handshake: both lines must be low.
                    if (!read && !write) begin
                        r_mfc      <= 1'b0;
                        r_rdata_oe <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata        = r_rdata;
    assign rdata_oe     = r_rdata_oe;
    assign mfc          = r_mfc;
    assign busy         = r_busy;
    assign protocol_err = r_protocol_err;
    assign rd_count     = r_rd_count;
    assign wr_count     = r_wr_count;

endmodule

// File: tb/tb_mem_mfc_responder.sv
// Testbench for mem_mfc_responder: default instance (WAIT_STATES=2) and a WAIT_STATES=0 instance.
// Directed vectors with hand-computed expectations; inputs driven and outputs sampled #1 after posedge.
// Every wait on mfc is bounded by a cycle budget.
module tb_mem_mfc_responder;

    logic        clock;
    logic        reset;
    logic        rd   [2];
    logic        wr   [2];
    logic [15:0] ad   [2];
    logic [15:0] wd   [2];
    logic [15:0] rdat [2];
    logic        oe   [2];
    logic        mfc  [2];
    logic        bsy  [2];
    logic        perr [2];
    logic [15:0] rdc  [2];
    logic [15:0] wrc  [2];

    int n_tests = 0;
    int n_fail  = 0;

    mem_mfc_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(2)) u_dut_ws2 (
        .clock(clock), .reset(reset), .read(rd[0]), .write(wr[0]), .addr(ad[0]), .wdata(wd[0]),
        .rdata(rdat[0]), .rdata_oe(oe[0]), .mfc(mfc[0]), .busy(bsy[0]), .protocol_err(perr[0]),
        .rd_count(rdc[0]), .wr_count(wrc[0])
    );

    mem_mfc_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(0)) u_dut_ws0 (
        .clock(clock), .reset(reset), .read(rd[1]), .write(wr[1]), .addr(ad[1]), .wdata(wd[1]),
        .rdata(rdat[1]), .rdata_oe(oe[1]), .mfc(mfc[1]), .busy(bsy[1]), .protocol_err(perr[1]),
        .rd_count(rdc[1]), .wr_count(wrc[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raise a request, scramble addr/wdata after acceptance, and count edges until mfc.
    // The request line stays high on return; release() completes the handshake.
    task automatic access(input int s, input bit is_wr, input logic [15:0] a,
                          input logic [15:0] d, input int lat, input string tag);
        int n;
        rd[s] = !is_wr;
        wr[s] = is_wr;
        ad[s] = a;
        wd[s] = d;
        tick();
        ad[s] = 16'hDEAD;
        wd[s] = 16'h0BAD;
        n = 0;
        while (!mfc[s] && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, lat);
    endtask

    task automatic release_req(input int s, input string tag);
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        tick();
        chk({tag, "_rel_mfc"}, mfc[s], 0);
        chk({tag, "_rel_oe"}, oe[s], 0);
        chk({tag, "_rel_busy"}, bsy[s], 0);
    endtask

    task automatic chk_reset_state(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk({tag, "_rdata"}, rdat[s], 0);
            chk({tag, "_oe"}, oe[s], 0);
            chk({tag, "_mfc"}, mfc[s], 0);
            chk({tag, "_busy"}, bsy[s], 0);
            chk({tag, "_perr"}, perr[s], 0);
            chk({tag, "_rdc"}, rdc[s], 0);
            chk({tag, "_wrc"}, wrc[s], 0);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rd[s] = 1'b0;
            wr[s] = 1'b0;
            ad[s] = 16'h0;
            wd[s] = 16'h0;
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_state("reset");

        // 1: write then read, 3-edge latency, and 2: handshake hold
        access(0, 1'b1, 16'h0010, 16'hBEEF, 3, "t1_wr");
        chk("t1_wr_busy", bsy[0], 1);
        release_req(0, "t1_wr");
        access(0, 1'b0, 16'h0010, 16'h0000, 3, "t1_rd");
        chk("t1_rdata", rdat[0], 16'hBEEF);
        chk("t1_oe", oe[0], 1);
        repeat (10) tick();
        chk("t2_mfc_held", mfc[0], 1);
        chk("t2_oe_held", oe[0], 1);
        chk("t2_rdc_held", rdc[0], 1);
        release_req(0, "t2");
        chk("t1_wrc", wrc[0], 1);
        chk("t1_rdc", rdc[0], 1);
        chk("t2_rdata_kept", rdat[0], 16'hBEEF);

        // 3: zero wait states
        access(1, 1'b1, 16'h0005, 16'h1234, 1, "t3_wr");
        release_req(1, "t3_wr");
        access(1, 1'b0, 16'h0005, 16'h0000, 1, "t3_rd");
        chk("t3_rdata", rdat[1], 16'h1234);
        release_req(1, "t3_rd");

        // 4: abort before mfc, then aliasing
        access(0, 1'b1, 16'h0003, 16'hAAAA, 3, "t4_wr");
        release_req(0, "t4_wr");
        wr[0] = 1'b1;
        ad[0] = 16'h0103;
        wd[0] = 16'h5555;
        tick();
        chk("t4_abort_busy_acc", bsy[0], 1);
        wr[0] = 1'b0;
        tick();
        chk("t4_abort_busy", bsy[0], 0);
        repeat (4) tick();
        chk("t4_abort_mfc", mfc[0], 0);
        chk("t4_abort_wrc", wrc[0], 2);
        access(0, 1'b0, 16'h0003, 16'h0000, 3, "t4_rd1");
        chk("t4_rdata_old", rdat[0], 16'hAAAA);
        release_req(0, "t4_rd1");
        access(0, 1'b1, 16'h0103, 16'h5555, 3, "t4_wr2");
        release_req(0, "t4_wr2");
        access(0, 1'b0, 16'h0003, 16'h0000, 3, "t4_rd2");
        chk("t4_rdata_alias", rdat[0], 16'h5555);
        release_req(0, "t4_rd2");
        chk("t4_wrc", wrc[0], 3);

        // 5: protocol error is sticky and does no access
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        ad[0] = 16'h0003;
        wd[0] = 16'h7777;
        tick();
        chk("t5_perr", perr[0], 1);
        chk("t5_busy", bsy[0], 0);
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        repeat (3) tick();
        chk("t5_perr_sticky", perr[0], 1);
        chk("t5_wrc", wrc[0], 3);
        access(0, 1'b0, 16'h0003, 16'h0000, 3, "t5_rd");
        chk("t5_rdata", rdat[0], 16'h5555);
        release_req(0, "t5_rd");

        // 6: reset mid-access aborts the write
        access(0, 1'b1, 16'h0007, 16'h0042, 3, "t6_wr");
        release_req(0, "t6_wr");
        wr[0] = 1'b1;
        ad[0] = 16'h0007;
        wd[0] = 16'hFFFF;
        tick();
        tick();
        chk("t6_busy_mid", bsy[0], 1);
        reset = 1'b1;
        wr[0] = 1'b0;
        tick();
        reset = 1'b0;
        chk_reset_state("t6_reset");
        access(0, 1'b0, 16'h0007, 16'h0000, 3, "t6_rd");
        chk("t6_rdata", rdat[0], 16'h0042);
        release_req(0, "t6_rd");
        chk("t6_wrc", wrc[0], 0);
        chk("t6_rdc", rdc[0], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
